// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared opcodes, register addresses and FSM state encoding for the command sequencer.
package reg_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int REG_ALU_A = 0;
    localparam int REG_ALU_B = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_RD,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

endpackage

// File: rtl/reg_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and its RX, register file, ALU and TX neighbours.
interface reg_cmd_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = 4
);
    logic [DATA_WIDTH-1:0]    i_RX_Data;
    logic                     i_RX_Valid;
    logic                     o_WrEn;
    logic                     o_RdEn;
    logic [ADDR_WIDTH-1:0]    o_Address;
    logic [DATA_WIDTH-1:0]    o_WrData;
    logic [DATA_WIDTH-1:0]    i_RdData;
    logic                     i_RdData_Valid;
    logic                     o_ALU_En;
    logic [FUN_WIDTH-1:0]     o_ALU_Fun;
    logic                     o_ALU_CLK_EN;
    logic [ALU_OUT_WIDTH-1:0] i_ALU_Out;
    logic                     i_ALU_Valid;
    logic [DATA_WIDTH-1:0]    o_TX_Data;
    logic                     o_TX_Valid;
    logic                     i_TX_Full;
    logic                     o_Busy;

    modport master (
        input  i_RX_Data, i_RX_Valid, i_RdData, i_RdData_Valid, i_ALU_Out, i_ALU_Valid, i_TX_Full,
        output o_WrEn, o_RdEn, o_Address, o_WrData, o_ALU_En, o_ALU_Fun, o_ALU_CLK_EN,
               o_TX_Data, o_TX_Valid, o_Busy
    );

    modport slave (
        output i_RX_Data, i_RX_Valid, i_RdData, i_RdData_Valid, i_ALU_Out, i_ALU_Valid, i_TX_Full,
        input  o_WrEn, o_RdEn, o_Address, o_WrData, o_ALU_En, o_ALU_Fun, o_ALU_CLK_EN,
               o_TX_Data, o_TX_Valid, o_Busy
    );

endinterface

// File: rtl/reg_cmd_ctrl_timeout.sv
// Inter-byte timeout counter, built only when CMD_TIMEOUT_EN is defined.
// Saturates at TIMEOUT_CYCLES so a stalled frame keeps reporting expiry until the next byte.
`ifdef CMD_TIMEOUT_EN
module reg_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= '0;
        else if (clear)               cnt <= '0;
        else if (count_en && !expired) cnt <= cnt + CW'(1);
    end

endmodule
`endif

// File: rtl/reg_cmd_ctrl.sv
// Command sequencer: parses framed RX bytes into register file writes/reads and ALU launches, pushes replies to TX.
// Define CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES cycles without an RX byte.
module reg_cmd_ctrl
    import reg_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic           i_CLK,
    input  logic           i_RST,
    reg_cmd_ctrl_if.master bus
);

    state_t                   state_q, state_n;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_n;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_n;
    logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_n;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_n;
    logic [DATA_WIDTH-1:0]    rd_byte_q, rd_byte_n;
    logic [ALU_OUT_WIDTH-1:0] result_q, result_n;
    logic wr_en_q, wr_en_n, rd_en_q, rd_en_n, alu_en_q, alu_en_n;
    logic tx_valid_q, tx_valid_n, clk_en_q, clk_en_n, busy_q, busy_n;
    logic abort;

    if (ALU_OUT_WIDTH != 2 * DATA_WIDTH) begin : g_bad_alu_width
        $error("ALU_OUT_WIDTH must equal 2*DATA_WIDTH");
    end

`ifdef CMD_TIMEOUT_EN
    logic timed, expired;

    // Only frame-collection states are timed; wait/TX states depend on neighbours, not the host.
    assign timed = state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_ALU_A, ST_ALU_B, ST_ALU_FUN};
    assign abort = timed && expired;

    reg_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (i_CLK),
        .rst      (i_RST),
        .clear    (bus.i_RX_Valid && (timed || state_q == ST_IDLE)),
        .count_en (timed),
        .expired  (expired)
    );
`else
    assign abort = 1'b0;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end
`endif

    always_comb begin
        state_n    = state_q;
        addr_n     = addr_q;
        wr_data_n  = wr_data_q;
        alu_fun_n  = alu_fun_q;
        tx_data_n  = tx_data_q;
        rd_byte_n  = rd_byte_q;
        result_n   = result_q;
        wr_en_n    = 1'b0;
        rd_en_n    = 1'b0;
        alu_en_n   = 1'b0;
        tx_valid_n = 1'b0;

        case (state_q)
            ST_IDLE: if (bus.i_RX_Valid) begin
                case (bus.i_RX_Data)
                    DATA_WIDTH'(CMD_WR):      state_n = ST_WR_ADDR;
                    DATA_WIDTH'(CMD_RD):      state_n = ST_RD_ADDR;
                    DATA_WIDTH'(CMD_ALU_OP):  state_n = ST_ALU_A;
                    DATA_WIDTH'(CMD_ALU_NOP): state_n = ST_ALU_FUN;
                    default:                  state_n = ST_IDLE;
                endcase
            end
            ST_WR_ADDR: if (bus.i_RX_Valid) begin
                addr_n  = bus.i_RX_Data[ADDR_WIDTH-1:0];
                state_n = ST_WR_DATA;
            end
            ST_WR_DATA: if (bus.i_RX_Valid) begin
                wr_data_n = bus.i_RX_Data;
                wr_en_n   = 1'b1;
                state_n   = ST_IDLE;
            end
            ST_RD_ADDR: if (bus.i_RX_Valid) begin
                addr_n  = bus.i_RX_Data[ADDR_WIDTH-1:0];
                rd_en_n = 1'b1;
                state_n = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (bus.i_RdData_Valid) begin
                rd_byte_n = bus.i_RdData;
                state_n   = ST_TX_RD;
            end
            ST_TX_RD: if (!bus.i_TX_Full) begin
                tx_data_n  = rd_byte_q;
                tx_valid_n = 1'b1;
                state_n    = ST_IDLE;
            end
            ST_ALU_A: if (bus.i_RX_Valid) begin
                addr_n    = ADDR_WIDTH'(REG_ALU_A);
                wr_data_n = bus.i_RX_Data;
                wr_en_n   = 1'b1;
                state_n   = ST_ALU_B;
            end
            ST_ALU_B: if (bus.i_RX_Valid) begin
                addr_n    = ADDR_WIDTH'(REG_ALU_B);
                wr_data_n = bus.i_RX_Data;
                wr_en_n   = 1'b1;
                state_n   = ST_ALU_FUN;
            end
            ST_ALU_FUN: if (bus.i_RX_Valid) begin
                alu_fun_n = bus.i_RX_Data[FUN_WIDTH-1:0];
                alu_en_n  = 1'b1;
                state_n   = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: if (bus.i_ALU_Valid) begin
                result_n = bus.i_ALU_Out;
                state_n  = ST_TX_LO;
            end
            ST_TX_LO: if (!bus.i_TX_Full) begin
                tx_data_n  = result_q[DATA_WIDTH-1:0];
                tx_valid_n = 1'b1;
                state_n    = ST_TX_HI;
            end
            ST_TX_HI: if (!bus.i_TX_Full) begin
                tx_data_n  = result_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
                tx_valid_n = 1'b1;
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // A stalled frame is dropped silently, even if its final byte lands in the expiry cycle.
        if (abort) begin
            state_n  = ST_IDLE;
            wr_en_n  = 1'b0;
            rd_en_n  = 1'b0;
            alu_en_n = 1'b0;
        end

        // Derived from the next state so the registered enables line up with the state they describe.
        clk_en_n = (state_n == ST_ALU_FUN) || (state_n == ST_ALU_WAIT);
        busy_n   = (state_n != ST_IDLE);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wr_data_q  <= '0;
            alu_fun_q  <= '0;
            tx_data_q  <= '0;
            rd_byte_q  <= '0;
            result_q   <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            wr_data_q  <= wr_data_n;
            alu_fun_q  <= alu_fun_n;
            tx_data_q  <= tx_data_n;
            rd_byte_q  <= rd_byte_n;
            result_q   <= result_n;
            wr_en_q    <= wr_en_n;
            rd_en_q    <= rd_en_n;
            alu_en_q   <= alu_en_n;
            tx_valid_q <= tx_valid_n;
            clk_en_q   <= clk_en_n;
            busy_q     <= busy_n;
        end
    end

    assign bus.o_WrEn       = wr_en_q;
    assign bus.o_RdEn       = rd_en_q;
    assign bus.o_Address    = addr_q;
    assign bus.o_WrData     = wr_data_q;
    assign bus.o_ALU_En     = alu_en_q;
    assign bus.o_ALU_Fun    = alu_fun_q;
    assign bus.o_ALU_CLK_EN = clk_en_q;
    assign bus.o_TX_Data    = tx_data_q;
    assign bus.o_TX_Valid   = tx_valid_q;
    assign bus.o_Busy       = busy_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Randomised bench for reg_cmd_ctrl: a command-level model predicts register writes, reads, ALU launches and TX bytes.
module tb_reg_cmd_ctrl;

    localparam int DW = 8, AW = 4, OW = 16, FW = 4, TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW), .FUN_WIDTH(FW)) bus ();

    reg_cmd_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    int vecs = 0;
    int errs = 0;
    // Event word: {kind, addr, data}; kind 1=write 2=read 3=alu 4=tx 0xEE=protocol violation
    logic [31:0] obs_ev[$];
    logic [31:0] exp_ev[$];
    int          obs_ptr = 0;
    logic [7:0]  mem_m [16];
    logic [7:0]  rf_mem [16];
    logic        alu_force_en;
    logic [15:0] alu_force_val;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        case (fun[1:0])
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) * 16'(b);
            2'd2:    return {a, b};
            default: return 16'(a) - 16'(b);
        endcase
    endfunction

    // Register file and ALU neighbours
    initial begin : responder
        int          alu_wait;
        logic [15:0] alu_res;
        foreach (rf_mem[i]) rf_mem[i] = 8'h00;
        bus.i_RdData = '0; bus.i_RdData_Valid = 1'b0;
        bus.i_ALU_Out = '0; bus.i_ALU_Valid = 1'b0;
        alu_wait = 0; alu_res = '0;
        forever begin
            @(posedge clk); #1;
            bus.i_RdData_Valid = 1'b0;
            bus.i_ALU_Valid    = 1'b0;
            if (bus.o_WrEn) rf_mem[bus.o_Address] = bus.o_WrData;
            if (bus.o_RdEn) begin
                bus.i_RdData = rf_mem[bus.o_Address];
                bus.i_RdData_Valid = 1'b1;
            end
            if (bus.o_ALU_En) begin
                alu_res  = alu_force_en ? alu_force_val : alu_f(rf_mem[0], rf_mem[1], bus.o_ALU_Fun);
                alu_wait = $urandom_range(1, 4);
            end else if (alu_wait > 0) begin
                alu_wait--;
                if (alu_wait == 0) begin
                    bus.i_ALU_Out   = alu_res;
                    bus.i_ALU_Valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_WrEn)     obs_ev.push_back({8'd1, 4'h0, bus.o_Address, 8'h00, bus.o_WrData});
            if (bus.o_RdEn)     obs_ev.push_back({8'd2, 4'h0, bus.o_Address, 16'h0000});
            if (bus.o_ALU_En)   obs_ev.push_back({8'd3, 20'h0, bus.o_ALU_Fun});
            if (bus.o_TX_Valid) obs_ev.push_back({8'd4, 16'h0, bus.o_TX_Data});
            if ((32'(bus.o_WrEn) + 32'(bus.o_RdEn) + 32'(bus.o_ALU_En)) > 1) obs_ev.push_back({8'hEE, 24'd1});
            if (bus.o_TX_Valid && bus.i_TX_Full)  obs_ev.push_back({8'hEE, 24'd2});
            if (bus.o_ALU_En && !bus.o_ALU_CLK_EN) obs_ev.push_back({8'hEE, 24'd3});
            if (bus.o_ALU_CLK_EN && !bus.o_Busy)   obs_ev.push_back({8'hEE, 24'd4});
            if (bus.i_ALU_Valid && bus.o_Busy && !bus.o_ALU_CLK_EN) obs_ev.push_back({8'hEE, 24'd5});
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus tasks assume the current time is just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        bus.i_RX_Data  = b;
        bus.i_RX_Valid = 1'b1;
        @(posedge clk); #1;
        bus.i_RX_Valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.o_Busy && n < 200);
        if (bus.o_Busy) begin
            vecs++; errs++;
            $display("FAIL idle_timeout: o_Busy still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        exp_ev.push_back({8'd1, 4'h0, a[3:0], 8'h00, d});
        mem_m[a[3:0]] = d;
    endtask

    task automatic m_read(input logic [7:0] a);
        exp_ev.push_back({8'd2, 4'h0, a[3:0], 16'h0000});
        exp_ev.push_back({8'd4, 16'h0, mem_m[a[3:0]]});
    endtask

    task automatic m_alu(input logic [7:0] f, input logic forced, input logic [15:0] fval);
        logic [15:0] r;
        r = forced ? fval : alu_f(mem_m[0], mem_m[1], f[3:0]);
        exp_ev.push_back({8'd3, 20'h0, f[3:0]});
        exp_ev.push_back({8'd4, 16'h0, r[7:0]});
        exp_ev.push_back({8'd4, 16'h0, r[15:8]});
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({bus.o_WrEn, bus.o_RdEn, bus.o_ALU_En, bus.o_TX_Valid, bus.o_ALU_CLK_EN} !== 5'b0) begin
            errs++; $display("FAIL reset_strobes: got %b required 00000",
                {bus.o_WrEn, bus.o_RdEn, bus.o_ALU_En, bus.o_TX_Valid, bus.o_ALU_CLK_EN});
        end
        vecs++;
        if ({bus.o_Address, bus.o_WrData, bus.o_ALU_Fun, bus.o_TX_Data} !== 24'h0) begin
            errs++; $display("FAIL reset_data: got %h required 000000",
                {bus.o_Address, bus.o_WrData, bus.o_ALU_Fun, bus.o_TX_Data});
        end
        vecs++;
        if (bus.o_Busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b required 0", bus.o_Busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        logic [7:0] a, d;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        m_write(8'h05, 8'h3C);
        wait_idle;
        vecs++;
        if (bus.o_Busy !== 1'b0) begin errs++; $display("FAIL write_busy: got %b required 0", bus.o_Busy); end
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom); d = 8'($urandom);
            send_byte(8'hAA); send_byte(a); send_byte(d);
            m_write(a, d);
            wait_idle;
        end
        vecs++;
        if (obs_ev.size() != obs_ptr + exp_ev.size()) begin
            errs++; $display("FAIL write_count: got %0d events required %0d", obs_ev.size() - obs_ptr, exp_ev.size());
        end else foreach (exp_ev[i]) begin
            vecs++;
            if (obs_ev[obs_ptr + i] !== exp_ev[i]) begin
                errs++; $display("FAIL write_ev%0d: got %h required %h", i, obs_ev[obs_ptr + i], exp_ev[i]);
            end
        end
        obs_ptr = obs_ev.size(); exp_ev.delete();
    endtask

    task automatic test_read;
        logic [7:0] a;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        m_write(8'h05, 8'h3C);
        send_byte(8'hBB); send_byte(8'h05);
        m_read(8'h05);
        wait_idle;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom);
            send_byte(8'hBB); send_byte(a);
            m_read(a);
            wait_idle;
        end
        vecs++;
        if (obs_ev.size() != obs_ptr + exp_ev.size()) begin
            errs++; $display("FAIL read_count: got %0d events required %0d", obs_ev.size() - obs_ptr, exp_ev.size());
        end else foreach (exp_ev[i]) begin
            vecs++;
            if (obs_ev[obs_ptr + i] !== exp_ev[i]) begin
                errs++; $display("FAIL read_ev%0d: got %h required %h", i, obs_ev[obs_ptr + i], exp_ev[i]);
            end
        end
        obs_ptr = obs_ev.size(); exp_ev.delete();
    endtask

    task automatic test_alu_op;
        logic [7:0] a, b, f;
        alu_force_en = 1'b1; alu_force_val = 16'h0246;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h01);
        m_write(8'h00, 8'h12); m_write(8'h01, 8'h34); m_alu(8'h01, 1'b1, 16'h0246);
        wait_idle;
        alu_force_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom); b = 8'($urandom); f = 8'($urandom);
            send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
            m_write(8'h00, a); m_write(8'h01, b); m_alu(f, 1'b0, 16'h0);
            wait_idle;
        end
        vecs++;
        if (obs_ev.size() != obs_ptr + exp_ev.size()) begin
            errs++; $display("FAIL alu_count: got %0d events required %0d", obs_ev.size() - obs_ptr, exp_ev.size());
        end else foreach (exp_ev[i]) begin
            vecs++;
            if (obs_ev[obs_ptr + i] !== exp_ev[i]) begin
                errs++; $display("FAIL alu_ev%0d: got %h required %h", i, obs_ev[obs_ptr + i], exp_ev[i]);
            end
        end
        obs_ptr = obs_ev.size(); exp_ev.delete();
    endtask

    task automatic test_alu_nop_full;
        bus.i_TX_Full = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        m_alu(8'h02, 1'b0, 16'h0);
        repeat (6) @(posedge clk);
        #1;
        send_byte(8'hAA);
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (obs_ev.size() != obs_ptr + 1) begin
            errs++; $display("FAIL full_hold: got %0d events while full required 1", obs_ev.size() - obs_ptr);
        end
        vecs++;
        if (bus.o_Busy !== 1'b1) begin errs++; $display("FAIL full_busy: got %b required 1", bus.o_Busy); end
        bus.i_TX_Full = 1'b0;
        wait_idle;
        vecs++;
        if (obs_ev.size() != obs_ptr + exp_ev.size()) begin
            errs++; $display("FAIL nop_count: got %0d events required %0d", obs_ev.size() - obs_ptr, exp_ev.size());
        end else foreach (exp_ev[i]) begin
            vecs++;
            if (obs_ev[obs_ptr + i] !== exp_ev[i]) begin
                errs++; $display("FAIL nop_ev%0d: got %h required %h", i, obs_ev[obs_ptr + i], exp_ev[i]);
            end
        end
        obs_ptr = obs_ev.size(); exp_ev.delete();
    endtask

    task automatic test_reset_mid;
        send_byte(8'hAA); send_byte(8'h07);
        rst = 1'b1;
        #1;
        vecs++;
        if (bus.o_Busy !== 1'b0) begin errs++; $display("FAIL async_reset_busy: got %b required 0", bus.o_Busy); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_byte(8'h55);
        repeat (4) @(posedge clk);
        #1;
        vecs++;
        if (bus.o_Busy !== 1'b0) begin errs++; $display("FAIL reset_mid_busy: got %b required 0", bus.o_Busy); end
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h77);
        m_write(8'h03, 8'h77);
        wait_idle;
        vecs++;
        if (obs_ev.size() != obs_ptr + exp_ev.size()) begin
            errs++; $display("FAIL reset_mid_count: got %0d events required %0d", obs_ev.size() - obs_ptr, exp_ev.size());
        end else foreach (exp_ev[i]) begin
            vecs++;
            if (obs_ev[obs_ptr + i] !== exp_ev[i]) begin
                errs++; $display("FAIL reset_mid_ev%0d: got %h required %h", i, obs_ev[obs_ptr + i], exp_ev[i]);
            end
        end
        obs_ptr = obs_ev.size(); exp_ev.delete();
    endtask

    task automatic test_partial_frame;
        send_byte(8'hAA); send_byte(8'h07);
        repeat (20) @(posedge clk);
        #1;
`ifdef CMD_TIMEOUT_EN
        vecs++;
        if (bus.o_Busy !== 1'b0) begin errs++; $display("FAIL timeout_busy: got %b required 0", bus.o_Busy); end
        send_byte(8'h99);
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (bus.o_Busy !== 1'b0) begin errs++; $display("FAIL timeout_stray: got busy %b required 0", bus.o_Busy); end
`else
        vecs++;
        if (bus.o_Busy !== 1'b1) begin errs++; $display("FAIL partial_busy: got %b required 1", bus.o_Busy); end
        send_byte(8'h99);
        m_write(8'h07, 8'h99);
        wait_idle;
`endif
        vecs++;
        if (obs_ev.size() != obs_ptr + exp_ev.size()) begin
            errs++; $display("FAIL partial_count: got %0d events required %0d", obs_ev.size() - obs_ptr, exp_ev.size());
        end else foreach (exp_ev[i]) begin
            vecs++;
            if (obs_ev[obs_ptr + i] !== exp_ev[i]) begin
                errs++; $display("FAIL partial_ev%0d: got %h required %h", i, obs_ev[obs_ptr + i], exp_ev[i]);
            end
        end
        obs_ptr = obs_ev.size(); exp_ev.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, d;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 8'h9F)));
            a = 8'($urandom); d = 8'($urandom);
            send_byte(8'hAA); send_byte(a); send_byte(d);
            m_write(a, d);
        end
        send_byte(8'hBB); send_byte(a);
        m_read(a);
        wait_idle;
        vecs++;
        if (obs_ev.size() != obs_ptr + exp_ev.size()) begin
            errs++; $display("FAIL b2b_count: got %0d events required %0d", obs_ev.size() - obs_ptr, exp_ev.size());
        end else foreach (exp_ev[i]) begin
            vecs++;
            if (obs_ev[obs_ptr + i] !== exp_ev[i]) begin
                errs++; $display("FAIL b2b_ev%0d: got %h required %h", i, obs_ev[obs_ptr + i], exp_ev[i]);
            end
        end
        obs_ptr = obs_ev.size(); exp_ev.delete();
    endtask

    initial begin : main
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        bus.i_RX_Data  = '0;
        bus.i_RX_Valid = 1'b0;
        bus.i_TX_Full  = 1'b0;
        alu_force_en   = 1'b0;
        alu_force_val  = '0;
        test_reset;
        test_write;
        test_read;
        test_alu_op;
        test_alu_nop_full;
        test_reset_mid;
        test_partial_frame;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
